// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and sequencer state encoding shared by the
//                alu_seq command sequencer and the top level around the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_NOT = 3'd4;
   localparam logic [2:0] OP_LSH = 3'd5;
   localparam logic [2:0] OP_RSH = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : One-command-at-a-time sequencer in front of the alu datapath.
//                Registers op/operands onto the ALU inputs, holds them for the
//                op latency (start pulse for shift/multiply), then captures
//                the ALU result into a one-entry output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int N         = 32,
   parameter int SHIFT_LAT = 2,
   parameter int MUL_LAT   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   output logic [2:0]   alu_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic         alu_inp,
   input  logic [N-1:0] alu_y_ext,
   input  logic [N-1:0] alu_y,
   input  logic         alu_flg,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_y_ext,
   output logic [N-1:0] res_y,
   output logic         res_flg,
   output logic         busy
);

   localparam int c_MAX_LAT = (SHIFT_LAT > MUL_LAT) ? SHIFT_LAT : MUL_LAT;
   localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
   localparam logic [c_CNT_W-1:0] c_SHIFT_LD = c_CNT_W'(SHIFT_LAT);
   localparam logic [c_CNT_W-1:0] c_MUL_LD   = c_CNT_W'(MUL_LAT);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_load;
   logic                 w_start;
   logic                 w_accept;
   logic                 w_capture;
   logic [2:0]           r_op;
   logic [N-1:0]         r_a;
   logic [N-1:0]         r_b;
   logic                 r_inp;
   logic [N-1:0]         r_res_y_ext;
   logic [N-1:0]         r_res_y;
   logic                 r_res_flg;

   assign w_accept  = cmd_valid && (r_state == ST_IDLE);
   assign w_capture = (r_state == ST_EXEC) && (r_cnt == '0);

   // Latency load value and start-pulse request decoded from the incoming opcode
   always_comb begin
      w_cnt_load = '0;
      w_start    = 1'b0;
      case (cmd_op)
         OP_LSH, OP_RSH: begin
            w_cnt_load = c_SHIFT_LD;
            w_start    = 1'b1;
         end
         OP_MUL: begin
            w_cnt_load = c_MUL_LD;
            w_start    = 1'b1;
         end
         default: begin
            w_cnt_load = '0;
            w_start    = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (cmd_valid) w_state_nxt = ST_EXEC;
         ST_EXEC: if (r_cnt == '0) w_state_nxt = ST_DONE;
         ST_DONE: if (res_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and status outputs; cmd_ready stays low while reset is held
   always_comb begin
      cmd_ready = (r_state == ST_IDLE) && rst_n;
      res_valid = (r_state == ST_DONE);
      busy      = (r_state != ST_IDLE);
   end

   // Command registers driving the ALU, held from accept until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op <= '0;
         r_a  <= '0;
         r_b  <= '0;
      end else if (w_accept) begin
         r_op <= cmd_op;
         r_a  <= cmd_a;
         r_b  <= cmd_b;
      end
   end

   // Start pulse: high only in the first EXEC cycle of shift/multiply ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_inp <= 1'b0;
      else        r_inp <= w_accept && w_start;
   end

   // Latency counter: loaded on accept, counts down to zero during EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_cnt_load;
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Result buffer: flag only meaningful for add/sub, high word only for mul
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_y_ext <= '0;
         r_res_y     <= '0;
         r_res_flg   <= 1'b0;
      end else if (w_capture) begin
         r_res_y     <= alu_y;
         r_res_y_ext <= (r_op == OP_MUL) ? alu_y_ext : '0;
         r_res_flg   <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? alu_flg : 1'b0;
      end
   end

   assign alu_op    = r_op;
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_inp   = r_inp;
   assign res_y_ext = r_res_y_ext;
   assign res_y     = r_res_y;
   assign res_flg   = r_res_flg;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq with a behavioural ALU whose
//                shift/multiply outputs only become valid after their latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   import alu_pkg::*;

   localparam int N         = 32;
   localparam int SHIFT_LAT = 2;
   localparam int MUL_LAT   = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [N-1:0]  cmd_a;
   logic [N-1:0]  cmd_b;
   logic [2:0]    alu_op;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic          alu_inp;
   logic [N-1:0]  alu_y_ext;
   logic [N-1:0]  alu_y;
   logic          alu_flg;
   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res_y_ext;
   logic [N-1:0]  res_y;
   logic          res_flg;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int age    = 0;
   bit seen   = 1'b0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic [31:0] ext;
      logic        flg;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic [31:0] ext;
      logic        flg;
      int          edge_n;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];

   alu_seq #(.N(N), .SHIFT_LAT(SHIFT_LAT), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp),
      .alu_y_ext(alu_y_ext), .alu_y(alu_y), .alu_flg(alu_flg),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y_ext(res_y_ext), .res_y(res_y), .res_flg(res_flg),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Cycles elapsed since the ALU saw its start pulse
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      age <= 0;
      else if (alu_inp)                age <= 1;
      else if (age != 0 && age < 100)  age <= age + 1;
   end

   function automatic int lat_of(input logic [2:0] op);
      if (op == OP_MUL)                        return MUL_LAT;
      else if (op == OP_LSH || op == OP_RSH)   return SHIFT_LAT;
      else                                     return 0;
   endfunction

   // Behavioural ALU: garbage until a multi-cycle op has had its latency;
   // flag and high word are driven with junk where they are not meaningful
   always_comb begin
      logic [63:0] prod;
      logic [32:0] sum;
      prod      = 64'(alu_a) * 64'(alu_b);
      sum       = {1'b0, alu_a} + {1'b0, alu_b};
      alu_y     = '0;
      alu_y_ext = 32'hFFFF_FFFF;
      alu_flg   = 1'b1;
      case (alu_op)
         OP_ADD: begin alu_y = sum[31:0]; alu_flg = sum[32]; end
         OP_SUB: begin alu_y = alu_a - alu_b; alu_flg = (alu_a < alu_b); end
         OP_AND: alu_y = alu_a & alu_b;
         OP_OR:  alu_y = alu_a | alu_b;
         OP_NOT: alu_y = ~alu_a;
         OP_LSH: alu_y = alu_a << alu_b[4:0];
         OP_RSH: alu_y = alu_a >> alu_b[4:0];
         default: begin alu_y = prod[31:0]; alu_y_ext = prod[63:32]; end
      endcase
      if (alu_op >= OP_LSH && age < lat_of(alu_op)) begin
         alu_y     = 32'hBAD0_BAD0;
         alu_y_ext = 32'h0BAD_0BAD;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: compare each result the first cycle res_valid is seen
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("spurious_res_valid", 64'(res_valid), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("res_y",       64'(res_y),     64'(e.y));
               chk("res_y_ext",   64'(res_y_ext), 64'(e.ext));
               chk("res_flg",     64'(res_flg),   64'(e.flg));
               chk("res_latency", 64'(cyc),       64'(e.edge_n));
            end
         end
         if (!res_valid) seen = 1'b0;
      end
   end

   // Drive one command from a negedge; returns the accepting edge index
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] y, input logic [31:0] ext, input logic flg,
                       output int acc_edge);
      int  tries = 0;
      bit  done  = 1'b0;
      exp_t e;
      acc_edge  = -1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      while (!done) begin
         if (cmd_ready) begin
            acc_edge = cyc + 1;
            e.y = y; e.ext = ext; e.flg = flg; e.edge_n = acc_edge + 1 + lat_of(op);
            sb.push_back(e);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("inp_first_exec", 64'(alu_inp), 64'(op >= OP_LSH));
            chk("alu_op",         64'(alu_op),  64'(op));
            chk("alu_a",          64'(alu_a),   64'(a));
            chk("alu_b",          64'(alu_b),   64'(b));
            chk("busy_exec",      64'(busy),    64'(1));
            chk("cmd_ready_exec", 64'(cmd_ready), 64'(0));
            @(negedge clk);
            chk("inp_second",     64'(alu_inp), 64'(0));
            done = 1'b1;
         end else if (tries >= 100) begin
            chk("accept_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
            done      = 1'b1;
         end else begin
            tries++;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, drain_edge;

      vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1'b1};
      vecs[1] = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1'b0};
      vecs[2] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1, 1'b0};
      vecs[3] = '{OP_SUB, 32'h3,         32'h5,         32'hFFFF_FFFE, 32'h0, 1'b1};
      vecs[4] = '{OP_LSH, 32'h1,         32'h4,         32'h10,        32'h0, 1'b0};
      vecs[5] = '{OP_RSH, 32'h8000_0000, 32'd31,        32'h1,         32'h0, 1'b0};
      vecs[6] = '{OP_NOT, 32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0, 32'h0, 1'b0};
      vecs[7] = '{OP_MUL, 32'h3,         32'h5,         32'hF,         32'h0, 1'b0};
      vecs[8] = '{OP_ADD, 32'h1,         32'h2,         32'h3,         32'h0, 1'b0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready_low", 64'(cmd_ready), 64'(0));
      chk("rst_res_valid",     64'(res_valid), 64'(0));
      chk("rst_alu_inp",       64'(alu_inp),   64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_res_y",     64'(res_y),     64'(0));

      // Table-driven pass
      for (int i = 0; i < 9; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ext, vecs[i].flg, a1);
         repeat (MUL_LAT + 2) @(negedge clk);
      end

      // Backpressure: result held, second command waits for the drain
      res_ready = 1'b0;
      send(OP_SUB, 32'd5, 32'd3, 32'd2, 32'h0, 1'b0, a1);
      cmd_op = OP_ADD; cmd_a = 32'd1; cmd_b = 32'd2; cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("bp_res_valid", 64'(res_valid), 64'(1));
         chk("bp_res_y",     64'(res_y),     64'(2));
         chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
         chk("bp_alu_a",     64'(alu_a),     64'(5));
         @(negedge clk);
      end
      res_ready  = 1'b1;
      drain_edge = cyc + 1;
      send(OP_ADD, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, a2);
      chk("bp_accept_after_drain", 64'(a2), 64'(drain_edge + 1));
      repeat (3) @(negedge clk);

      // Back-to-back OR then NOT
      send(OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0, 1'b0, a1);
      send(OP_NOT, 32'h5555_AAAA, 32'h0,         32'hAAAA_5555, 32'h0, 1'b0, a2);
      chk("b2b_spacing", 64'(a2 - a1), 64'(3));
      repeat (3) @(negedge clk);

      // Reset during the first EXEC cycle of a multiply
      cmd_op = OP_MUL; cmd_a = 32'd7; cmd_b = 32'd6; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mr_inp_high", 64'(alu_inp), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mr_alu_inp",   64'(alu_inp),   64'(0));
      chk("mr_alu_op",    64'(alu_op),    64'(0));
      chk("mr_alu_a",     64'(alu_a),     64'(0));
      chk("mr_alu_b",     64'(alu_b),     64'(0));
      chk("mr_res_y",     64'(res_y),     64'(0));
      chk("mr_res_valid", 64'(res_valid), 64'(0));
      chk("mr_busy",      64'(busy),      64'(0));
      chk("mr_cmd_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr_cmd_ready_after", 64'(cmd_ready), 64'(1));
      repeat (MUL_LAT + 4) @(negedge clk);
      chk("mr_no_stale_valid", 64'(res_valid), 64'(0));
      chk("mr_idle",           64'(busy),      64'(0));

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Command sequencer and result buffer directly upstream of the `alu` datapath. It accepts one ALU command at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It holds them stable for the op's latency, with a start pulse on `inp` for shift and multiply. It then captures `{y_ext, y, flg}` into a one-entry output buffer drained over a second valid/ready handshake.

## Interface
- `N`, 32: operand width; must match the connected `alu`.
- `SHIFT_LAT`, 2: cycles after issue before shift results are valid; ≥1.
- `MUL_LAT`, 4: cycles after issue before multiply result is valid; ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted this cycle when both high.
- `cmd_op` in 3: opcode; 0 add, 1 sub, 2 and, 3 or, 4 not, 5 lshift, 6 rshift, 7 mul.
- `cmd_a`, `cmd_b` in N: operands.
- `alu_op` out 3, `alu_a`/`alu_b` out N: registered ALU inputs.
- `alu_inp` out 1: one-cycle start pulse to ALU shifters/multiplier.
- `alu_y_ext`, `alu_y` in N, `alu_flg` in 1: ALU outputs.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_y_ext`, `res_y` out N, `res_flg` out 1: buffered result.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, register op/a/b onto `alu_*`, load the latency counter, and go to EXEC.
  - EXEC: `alu_*` held constant. Counter decrements each cycle. At count 0, capture ALU outputs into `res_*`, set `res_valid`, and go to DONE.
  - DONE: `res_*` held. When `res_ready`, clear `res_valid` and go to IDLE.
- Latency counter load value:
  - Ops 0–4: 0.
  - Ops 5–6: `SHIFT_LAT`.
  - Op 7: `MUL_LAT`.
  - Width is `$clog2(max(SHIFT_LAT,MUL_LAT)+1)`.
- `alu_inp`: high for exactly the first EXEC cycle of ops 5–7, else 0.
- Capture rules:
  - `res_flg` = `alu_flg` for ops 0–1; forced 0 for ops 2–7 (ALU flag is not driven there).
  - `res_y_ext` = `alu_y_ext` for op 7; forced 0 otherwise.
  - `res_y` = `alu_y` always.
- `cmd_ready` is low in EXEC and DONE; no command is accepted while a result is pending.
- Reset (any state, including mid-EXEC):
  - State → IDLE.
  - All outputs 0, except `cmd_ready`=1 once `rst_n` is high.
  - Any in-flight command is discarded.
  - `alu_inp` forced 0 asynchronously.

## Timing
- Accept at edge T (cmd_valid && cmd_ready): `alu_*` valid from T, state EXEC during cycle T..T+1.
- Ops 0–4: capture at edge T+1; `res_valid` high from T+1.
- Ops 5–7: capture at edge T+1+LAT; `res_valid` high from T+1+LAT.
- `res_valid` drops the edge after `res_valid && res_ready`. `cmd_ready` rises in the same edge, so the next command is accepted at the earliest one edge later.
- Best-case throughput: one combinational op per 3 cycles.
- `res_*` and `alu_*` never change while `res_valid`=1 or in EXEC.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_ADD…OP_MUL) and the FSM state enum. `alu_seq` and the top level share these.
- Single module; counter and capture logic inline. The ALU is instantiated beside it at the top level, not inside.

## Test plan
- ADD, a=0xFFFF_FFFF, b=1 → `res_y`=0, `res_flg`=`alu_flg` captured, `res_y_ext`=0, `res_valid` exactly one edge after accept.
- AND, a=0xF0F0_F0F0, b=0xFF00_FF00 → `res_y`=0xF000_F000, `res_flg`=0; `alu_inp` never asserted.
- MUL, MUL_LAT=4, a=0x0001_0000, b=0x0001_0000:
  - `alu_inp` high exactly in the first EXEC cycle.
  - `res_y_ext`=1, `res_y`=0, `res_valid` 5 edges after accept.
- Backpressure: hold `res_ready`=0 for 6 cycles after SUB 5−3.
  - `res_y`=2 stable and `cmd_ready`=0 throughout.
  - A second command presented meanwhile is accepted only after the drain.
- `rst_n` pulsed low during MUL EXEC:
  - Outputs 0 immediately, `alu_inp`=0.
  - After release, `cmd_ready`=1 and no stale `res_valid`.
- Back-to-back: OR then NOT with `res_ready`=1 → results 0x…OR and ~a in order. Accept edges are 3 cycles apart.
